// File: rtl/hisoc_tseq_pkg.sv
// Shared types and defaults for the hisoc multi-program test sequencer.
// Result codes are carried in a 32-bit field, so DATA_W is expected to be <= 32.
package hisoc_tseq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RESET,
        ST_LOAD,
        ST_RUN,
        ST_RECORD,
        ST_DONE
    } tseq_state_e;

    localparam logic [31:0] DEF_SIG_ADDR  = 32'h0000_1000;
    localparam logic [31:0] DEF_PASS_CODE = 32'h0000_0001;
    localparam int          RES_CODE_W    = 32;

    typedef struct packed {
        logic                  pass;
        logic                  timeout;
        logic [RES_CODE_W-1:0] code;
    } tseq_result_t;

    // Bits needed to hold the value v (at least 1).
    function automatic int bits_for(input int v);
        return (v < 2) ? 1 : $clog2(v + 1);
    endfunction

endpackage

// File: rtl/hisoc_tseq_cnt.sv
// Loadable down-counter with zero flag; shared by the reset hold and run timeout.
module hisoc_tseq_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/hisoc_test_seq.sv
// Multi-program test sequencer: resets, loads, runs and scores each program image in turn.
// Build option HISOC_TSEQ_STOP_ON_FAIL_EN: stop the campaign at the first failing test.
//
// state  | meaning
// IDLE   | after reset, core held in reset, waiting for start
// RESET  | core held in reset for RST_CYCLES
// LOAD   | load_req high, waiting for load_ack
// RUN    | core running, watching for the signature store or timeout
// RECORD | one-cycle result pulse, tallies updated
// DONE   | campaign finished, waiting for start
module hisoc_test_seq
    import hisoc_tseq_pkg::*;
#(
    parameter int                NUM_TESTS      = 37,
    parameter int                IDX_W          = 6,
    parameter int                RST_CYCLES     = 4,
    parameter int                TIMEOUT_CYCLES = 500,
    parameter int                ADDR_W         = 32,
    parameter int                DATA_W         = 32,
    parameter logic [ADDR_W-1:0] SIG_ADDR       = ADDR_W'(DEF_SIG_ADDR),
    parameter logic [DATA_W-1:0] PASS_CODE      = DATA_W'(DEF_PASS_CODE)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              core_rst_n,
    output logic              core_enable,
    output logic              load_req,
    input  logic              load_ack,
    output logic [IDX_W-1:0]  test_idx,
    input  logic              sig_we,
    input  logic [ADDR_W-1:0] sig_addr,
    input  logic [DATA_W-1:0] sig_wdata,
    output logic              result_valid,
    output logic              result_pass,
    output logic              result_timeout,
    output logic [DATA_W-1:0] result_code,
    output logic [IDX_W:0]    pass_cnt,
    output logic [IDX_W:0]    fail_cnt,
    output logic              busy,
    output logic              done
`ifdef HISOC_TSEQ_STOP_ON_FAIL_EN
    ,
    output logic              stopped_on_fail
`endif
);

    localparam int CNT_MAX = (RST_CYCLES > TIMEOUT_CYCLES) ? RST_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = bits_for(CNT_MAX - 1);

    localparam logic [CNT_W-1:0] RST_LOAD  = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] RUN_LOAD  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_TESTS - 1);
    localparam logic [IDX_W:0]   TALLY_ONE = (IDX_W + 1)'(1);

    tseq_state_e      state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    tseq_result_t     res_q, res_d;
    logic [IDX_W:0]   pass_q, fail_q;
    logic             clr_cnts;
    logic             cnt_load, cnt_dec, cnt_zero;
    logic [CNT_W-1:0] cnt_val;
    logic             hit;

`ifdef HISOC_TSEQ_STOP_ON_FAIL_EN
    logic stop_q, stop_d;
`endif

    assign hit     = sig_we && (sig_addr == SIG_ADDR);
    assign cnt_dec = (state_q == ST_RESET) || (state_q == ST_RUN);

    hisoc_tseq_cnt #(
        .W(CNT_W)
    ) u_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (cnt_load),
        .load_val(cnt_val),
        .dec     (cnt_dec),
        .zero    (cnt_zero)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        res_d    = res_q;
        clr_cnts = 1'b0;
        cnt_load = 1'b0;
        cnt_val  = '0;
`ifdef HISOC_TSEQ_STOP_ON_FAIL_EN
        stop_d   = stop_q;
`endif
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d  = ST_RESET;
                    idx_d    = '0;
                    clr_cnts = 1'b1;
                    cnt_load = 1'b1;
                    cnt_val  = RST_LOAD;
`ifdef HISOC_TSEQ_STOP_ON_FAIL_EN
                    stop_d   = 1'b0;
`endif
                end
            end
            ST_RESET: begin
                if (cnt_zero) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (load_ack) begin
                    state_d  = ST_RUN;
                    cnt_load = 1'b1;
                    cnt_val  = RUN_LOAD;
                end
            end
            ST_RUN: begin
                // A hit on the final timeout cycle still counts as a hit.
                if (hit) begin
                    res_d.pass    = (sig_wdata == PASS_CODE);
                    res_d.timeout = 1'b0;
                    res_d.code    = RES_CODE_W'(sig_wdata);
                    state_d       = ST_RECORD;
                end else if (cnt_zero) begin
                    res_d.pass    = 1'b0;
                    res_d.timeout = 1'b1;
                    res_d.code    = '0;
                    state_d       = ST_RECORD;
                end
            end
            ST_RECORD: begin
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
`ifdef HISOC_TSEQ_STOP_ON_FAIL_EN
                end else if (!res_q.pass) begin
                    state_d = ST_DONE;
                    stop_d  = 1'b1;
`endif
                end else begin
                    state_d  = ST_RESET;
                    idx_d    = idx_q + IDX_W'(1);
                    cnt_load = 1'b1;
                    cnt_val  = RST_LOAD;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            res_q   <= '0;
            pass_q  <= '0;
            fail_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            res_q   <= res_d;
            if (clr_cnts) begin
                pass_q <= '0;
                fail_q <= '0;
            end else if (state_q == ST_RECORD) begin
                if (res_q.pass) begin
                    if (pass_q != '1) pass_q <= pass_q + TALLY_ONE;
                end else begin
                    if (fail_q != '1) fail_q <= fail_q + TALLY_ONE;
                end
            end
        end
    end

`ifdef HISOC_TSEQ_STOP_ON_FAIL_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stop_q <= 1'b0;
        else        stop_q <= stop_d;
    end

    assign stopped_on_fail = (state_q == ST_DONE) && stop_q;
`endif

    assign core_rst_n     = (state_q == ST_RUN);
    assign core_enable    = (state_q == ST_RUN);
    assign load_req       = (state_q == ST_LOAD);
    assign result_valid   = (state_q == ST_RECORD);
    assign busy           = (state_q == ST_RESET) || (state_q == ST_LOAD) ||
                            (state_q == ST_RUN)   || (state_q == ST_RECORD);
    assign done           = (state_q == ST_DONE);
    assign test_idx       = idx_q;
    assign result_pass    = res_q.pass;
    assign result_timeout = res_q.timeout;
    assign result_code    = DATA_W'(res_q.code);
    assign pass_cnt       = pass_q;
    assign fail_cnt       = fail_q;

endmodule

// File: tb/tb_hisoc_test_seq.sv
// Randomized scoreboard bench for hisoc_test_seq: the driver plays loader and core,
// predicts each test's result from the scoring rules, and a monitor checks result pulses.
module tb_hisoc_test_seq;

    localparam int          NUM_TESTS      = 5;
    localparam int          IDX_W          = 3;
    localparam int          RST_CYCLES     = 4;
    localparam int          TIMEOUT_CYCLES = 30;
    localparam int          ADDR_W         = 32;
    localparam int          DATA_W         = 32;
    localparam logic [31:0] SIG_ADDR       = 32'h0000_1000;
    localparam logic [31:0] PASS_CODE      = 32'h0000_0001;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              load_ack = 1'b0;
    logic              sig_we = 1'b0;
    logic [ADDR_W-1:0] sig_addr = '0;
    logic [DATA_W-1:0] sig_wdata = '0;
    logic              core_rst_n, core_enable, load_req;
    logic [IDX_W-1:0]  test_idx;
    logic              result_valid, result_pass, result_timeout;
    logic [DATA_W-1:0] result_code;
    logic [IDX_W:0]    pass_cnt, fail_cnt;
    logic              busy, done;
`ifdef HISOC_TSEQ_STOP_ON_FAIL_EN
    logic              stopped_on_fail;
`endif

    hisoc_test_seq #(
        .NUM_TESTS     (NUM_TESTS),
        .IDX_W         (IDX_W),
        .RST_CYCLES    (RST_CYCLES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .ADDR_W        (ADDR_W),
        .DATA_W        (DATA_W),
        .SIG_ADDR      (SIG_ADDR),
        .PASS_CODE     (PASS_CODE)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .core_rst_n    (core_rst_n),
        .core_enable   (core_enable),
        .load_req      (load_req),
        .load_ack      (load_ack),
        .test_idx      (test_idx),
        .sig_we        (sig_we),
        .sig_addr      (sig_addr),
        .sig_wdata     (sig_wdata),
        .result_valid  (result_valid),
        .result_pass   (result_pass),
        .result_timeout(result_timeout),
        .result_code   (result_code),
        .pass_cnt      (pass_cnt),
        .fail_cnt      (fail_cnt),
        .busy          (busy),
        .done          (done)
`ifdef HISOC_TSEQ_STOP_ON_FAIL_EN
        ,
        .stopped_on_fail(stopped_on_fail)
`endif
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        pass;
        logic        timeout;
        logic [31:0] code;
        int unsigned at;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   force_kind[NUM_TESTS];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic abort_run(input string what);
        vectors++;
        miscompares++;
        $display("FAIL %s: no DUT response within cycle budget (cycle %0d)", what, cyc);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "bench stopped early");
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && result_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_result: result_valid with nothing expected (cycle %0d)", cyc);
            end else begin
                e = exp_q.pop_front();
                check("res_pass", 64'(result_pass), 64'(e.pass));
                check("res_timeout", 64'(result_timeout), 64'(e.timeout));
                check("res_code", 64'(result_code), 64'(e.code));
                check("res_cycle", 64'(cyc), 64'(e.at));
                check("record_core_off", 64'({core_rst_n, core_enable}), 64'(0));
            end
        end
    end

    // Kinds: 0 pass store, 1 failing store, 2 no store (timeout), 3 pass store on the last allowed cycle.
    task automatic run_test(input int idx, input int forced, input bit first, output bit passed);
        int          n, ack_lat, kind, h, r;
        bit          will_hit;
        logic [31:0] code;
        exp_t        e;

        n = 0;
        while (load_req !== 1'b1) begin
            if (n > RST_CYCLES + 4) abort_run("load_req_wait");
            @(negedge clk);
            n++;
        end
        check("reset_hold_len", 64'(n), 64'(first ? RST_CYCLES : RST_CYCLES + 1));
        check("load_idx", 64'(test_idx), 64'(idx));
        check("load_core_in_reset", 64'({core_rst_n, core_enable}), 64'(0));

        ack_lat = $urandom_range(1, 6);
        for (int k = 1; k < ack_lat; k++) begin
            @(negedge clk);
            check("load_req_held", 64'(load_req), 64'(1));
            check("load_core_rst_low", 64'(core_rst_n), 64'(0));
        end
        load_ack = 1'b1;
        @(negedge clk);
        load_ack = 1'b0;
        check("load_req_dropped", 64'(load_req), 64'(0));
        check("run_core_on", 64'({core_rst_n, core_enable}), 64'(3));

        kind = (forced >= 0) ? forced : int'($urandom_range(0, 4));
        if (kind > 3) kind = 0;
        will_hit = (kind != 2);
        h        = (kind == 3) ? TIMEOUT_CYCLES - 1 : int'($urandom_range(0, TIMEOUT_CYCLES - 1));
        code     = PASS_CODE;
        if (kind == 1) begin
            code = (forced == 1 || $urandom_range(0, 1) == 0) ? 32'h0000_DEAD : $urandom;
            if (code == PASS_CODE) code = 32'h0000_DEAD;
        end
        if (will_hit) begin
            e.pass    = (code == PASS_CODE);
            e.timeout = 1'b0;
            e.code    = code;
            e.at      = cyc + h + 1;
        end else begin
            e.pass    = 1'b0;
            e.timeout = 1'b1;
            e.code    = '0;
            e.at      = cyc + TIMEOUT_CYCLES;
        end
        exp_q.push_back(e);
        passed = e.pass;

        for (int k = 0; ; k++) begin
            if (result_valid === 1'b1) break;
            if (k > TIMEOUT_CYCLES + 2) abort_run("record_wait");
            sig_we    = 1'b0;
            sig_addr  = $urandom;
            sig_wdata = $urandom;
            start     = ($urandom_range(0, 7) == 0);
            load_ack  = ($urandom_range(0, 7) == 0);
            if (will_hit && k == h) begin
                sig_we    = 1'b1;
                sig_addr  = SIG_ADDR;
                sig_wdata = code;
            end else begin
                r = $urandom_range(0, 3);
                if (r == 0) begin
                    sig_we    = 1'b1;
                    sig_addr  = SIG_ADDR + 32'd4;
                    sig_wdata = PASS_CODE;
                end else if (r == 1) begin
                    sig_addr  = SIG_ADDR;
                    sig_wdata = PASS_CODE;
                end
            end
            @(negedge clk);
        end
        sig_we   = 1'b0;
        start    = 1'b0;
        load_ack = 1'b0;
    endtask

    task automatic run_campaign();
        int npass, nfail, last;
        bit p, stopped;
        npass   = 0;
        nfail   = 0;
        last    = 0;
        stopped = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_busy", 64'(busy), 64'(1));
        check("start_done_low", 64'(done), 64'(0));
        check("start_cnt_clear", 64'({pass_cnt, fail_cnt}), 64'(0));
        for (int i = 0; i < NUM_TESTS; i++) begin
            run_test(i, force_kind[i], (i == 0), p);
            last = i;
            if (p) npass++;
            else   nfail++;
`ifdef HISOC_TSEQ_STOP_ON_FAIL_EN
            if (!p && i != NUM_TESTS - 1) begin
                stopped = 1'b1;
                break;
            end
`endif
        end
        @(negedge clk);
        check("done_high", 64'(done), 64'(1));
        check("done_busy_low", 64'(busy), 64'(0));
        check("done_pass_cnt", 64'(pass_cnt), 64'(npass));
        check("done_fail_cnt", 64'(fail_cnt), 64'(nfail));
        check("done_test_idx", 64'(test_idx), 64'(last));
        check("done_core_off", 64'({core_rst_n, core_enable, load_req}), 64'(0));
        check("done_all_results", 64'(exp_q.size()), 64'(0));
`ifdef HISOC_TSEQ_STOP_ON_FAIL_EN
        check("stopped_on_fail", 64'(stopped_on_fail), 64'(stopped));
`else
        check("no_early_stop", 64'(stopped), 64'(0));
`endif
    endtask

    initial begin
        int n;
        bit p;

        repeat (3) @(negedge clk);
        check("rst_core_rst_n", 64'(core_rst_n), 64'(0));
        check("rst_core_enable", 64'(core_enable), 64'(0));
        check("rst_load_req", 64'(load_req), 64'(0));
        check("rst_test_idx", 64'(test_idx), 64'(0));
        check("rst_results", 64'({result_valid, result_pass, result_timeout, result_code}), 64'(0));
        check("rst_counts", 64'({pass_cnt, fail_cnt}), 64'(0));
        check("rst_busy_done", 64'({busy, done}), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Directed campaign: pass, 0xDEAD failure, last-cycle hit, timeout, pass.
        force_kind = '{0, 1, 3, 2, 0};
        run_campaign();

        for (int c = 0; c < 6; c++) begin
            for (int i = 0; i < NUM_TESTS; i++) force_kind[i] = -1;
            run_campaign();
        end

        // Reset asserted while test 1 is running.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        run_test(0, 0, 1'b1, p);
        n = 0;
        while (load_req !== 1'b1) begin
            if (n > RST_CYCLES + 4) abort_run("midrun_load_wait");
            @(negedge clk);
            n++;
        end
        load_ack = 1'b1;
        @(negedge clk);
        load_ack = 1'b0;
        repeat (3) @(negedge clk);
        check("midrun_running", 64'({core_rst_n, core_enable}), 64'(3));
        check("midrun_pass_cnt", 64'(pass_cnt), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        check("async_core_rst_n", 64'(core_rst_n), 64'(0));
        check("async_core_enable", 64'(core_enable), 64'(0));
        check("async_busy_done", 64'({busy, done}), 64'(0));
        check("async_counts", 64'({pass_cnt, fail_cnt}), 64'(0));
        check("async_test_idx", 64'(test_idx), 64'(0));
        check("async_results", 64'({result_pass, result_timeout, result_code}), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_idle", 64'({busy, done, load_req}), 64'(0));

        for (int i = 0; i < NUM_TESTS; i++) force_kind[i] = -1;
        run_campaign();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
